// File: rtl/column_scan_controller.sv
// Column scan controller for the i4001 front-panel key matrix.
// Steps a 4-bit column selector while mode is input (0), waits DWELL_CYCLES
// on each column, samples the four row lines and debounces all 64 keys.
// Debounced press/release transitions are reported one at a time.
//
// Event handshake (key_valid / key_ready):
//   An event transfers on a rising edge where key_valid && key_ready.
//   key_valid is raised without waiting for key_ready.
//   Once raised, key_valid, key_code and key_press hold steady until the event
//   is accepted. The only exceptions are a mode exit or reset, which discard it.
//   While an event is outstanding the scan stalls: the selector holds and no
//   sampling takes place.
module column_scan_controller #(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [3:0] row_in,
  output logic [3:0] selector,
  output logic       scan_active,
  output logic       frame_tick,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [5:0] key_code,
  output logic       key_press,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_EMIT   = 3'd3,
    S_NEXT   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_ONE    = CNT_W'(1);
  localparam logic [3:0]       DEB_LAST     = 4'(DEBOUNCE_SCANS - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       dwell_q;
  logic [3:0]             sel_q;
  logic [15:0][3:0]       stable_q;   // debounced level per key, 1 = pressed
  logic [15:0][3:0][3:0]  cnt_q;      // consecutive differing samples per key
  logic [3:0]             pending_q;  // rows of the current column awaiting report
  logic                   active_q;
  logic                   tick_q;
  logic                   valid_q;
  logic [5:0]             code_q;
  logic                   press_q;

  logic [3:0]             flip_d;
  logic [3:0]             stable_col_d;
  logic [3:0][3:0]        cnt_col_d;
  logic [1:0]             flip_row_d;
  logic [3:0]             pend_rem_d;
  logic [1:0]             rem_row_d;

  // Lowest set bit index; ascending row order for simultaneous events.
  function automatic logic [1:0] lowest_row(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Debounce update for the selected column and next pending row after an accept.
  always_comb begin
    flip_d       = '0;
    stable_col_d = stable_q[sel_q];
    cnt_col_d    = cnt_q[sel_q];
    for (int r = 0; r < 4; r++) begin
      if (row_in[r] == stable_q[sel_q][r]) begin
        cnt_col_d[r] = '0;
      end else if (cnt_q[sel_q][r] == DEB_LAST) begin
        cnt_col_d[r]    = '0;
        flip_d[r]       = 1'b1;
        stable_col_d[r] = row_in[r];
      end else begin
        cnt_col_d[r] = cnt_q[sel_q][r] + 4'd1;
      end
    end
    flip_row_d = lowest_row(flip_d);
    pend_rem_d = pending_q & ~(4'b0001 << code_q[1:0]);
    rem_row_d  = lowest_row(pend_rem_d);
  end

  // Scan FSM with registered outputs; any non-input mode forces a full clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dwell_q   <= '0;
      sel_q     <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      active_q  <= 1'b0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      press_q   <= 1'b0;
    end else if (mode != 2'd0) begin
      state_q   <= S_IDLE;
      dwell_q   <= '0;
      sel_q     <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      active_q  <= 1'b0;
      tick_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          dwell_q  <= DWELL_RELOAD;
          active_q <= 1'b1;
          state_q  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (dwell_q == '0) state_q <= S_SAMPLE;
          else               dwell_q <= dwell_q - DWELL_ONE;
        end
        S_SAMPLE: begin
          stable_q[sel_q] <= stable_col_d;
          cnt_q[sel_q]    <= cnt_col_d;
          pending_q       <= flip_d;
          if (flip_d != 4'd0) begin
            valid_q <= 1'b1;
            code_q  <= {sel_q, flip_row_d};
            press_q <= stable_col_d[flip_row_d];
            state_q <= S_EMIT;
          end else begin
            state_q <= S_NEXT;
          end
        end
        S_EMIT: begin
          if (key_ready) begin
            pending_q <= pend_rem_d;
            if (pend_rem_d != 4'd0) begin
              code_q  <= {sel_q, rem_row_d};
              press_q <= stable_q[sel_q][rem_row_d];
            end else begin
              valid_q <= 1'b0;
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          sel_q   <= sel_q + 4'd1;
          tick_q  <= (sel_q == 4'd15);
          dwell_q <= DWELL_RELOAD;
          state_q <= S_SETTLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign selector    = sel_q;
  assign scan_active = active_q;
  assign frame_tick  = tick_q;
  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_press   = press_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/column_scan_controller.md
Name: column_scan_controller

Overview:
- Sequences the 4-bit column selector of the i4001 front panel while mode = 0 (input).
- Dwells on each column, samples the 4 key-row lines, and debounces each of the 64 keys (16 columns x 4 rows).
- Reports each debounced press/release as an event over a valid/ready handshake.
- Sits between the panel key matrix and the program-entry logic; its selector output feeds the column-select ROM.

Parameters:
- DWELL_CYCLES, 1000, clock cycles the selector is held before row_in is sampled (>= 1).
- DEBOUNCE_SCANS, 3, consecutive per-column samples a key must differ from its stable state before it flips (1..15).
- CNT_W, 16, width of the dwell counter (must hold DWELL_CYCLES-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  0 = input (scan), 1 = run, 2 = debug; any value other than 0 halts scanning.
- row_in  in  4  key rows sensed for the currently selected column, 1 = pressed.
- selector  out  4  column index driven to the column-select ROM.
- scan_active  out  1  high whenever the FSM is not in IDLE.
- frame_tick  out  1  one-cycle pulse when selector wraps 15 -> 0.
- key_valid  out  1  event available.
- key_ready  in  1  consumer accepts the event.
- key_code  out  6  event key: {column[3:0], row[1:0]}.
- key_press  out  1  1 = press, 0 = release.

Behaviour:
- Reset (async, rst_n low), outputs: selector = 0, scan_active = 0, frame_tick = 0, key_valid = 0, key_code = 0, key_press = 0.
- Reset, internal state: all 64 stable bits = released; all per-key counters = 0; pending mask = 0; state = IDLE.
- Reset mid-operation: same result, regardless of state or handshake.
- States:
  - IDLE: selector held at 0. If mode == 0, load dwell = DWELL_CYCLES-1 and go to SETTLE.
  - SETTLE: dwell counter decrements. When it reaches 0, go to SAMPLE. Selector-change-to-sample latency = DWELL_CYCLES cycles.
  - SAMPLE (1 cycle): evaluate row_in for each row r of column c = selector.
    - If row_in[r] equals stable[c][r], the counter is cleared.
    - Otherwise the counter increments. On reaching DEBOUNCE_SCANS: stable[c][r] flips, counter clears, pending[r] sets.
    - If pending != 0, go to EMIT; else go to NEXT.
  - EMIT: key_valid = 1. key_code = {c, lowest set pending row}. key_press = new stable value of that key.
    - On key_valid && key_ready: clear that pending bit.
    - If more bits remain, present the next row on the following cycle (valid stays high). Otherwise go to NEXT.
    - Sample-to-valid latency = 1 cycle.
  - NEXT (1 cycle): selector <= selector + 1 (mod 16). At 15 -> 0, frame_tick = 1 for that cycle. Reload dwell, go to SETTLE.
- Scan period with no events = DWELL_CYCLES + 2 cycles per column; one frame = 16 x (DWELL_CYCLES + 2).
- Handshake rules:
  - key_code and key_press are stable while key_valid && !key_ready.
  - key_valid never drops without acceptance, except on a mode exit or reset.
  - Backpressure stalls the scan: selector holds, and no sampling occurs, while in EMIT.
- Mode exit (mode != 0, any state):
  - Next clock: state = IDLE, selector = 0, key_valid = 0, pending = 0. Any pending events are discarded.
  - All stable bits and counters clear to released; no release events are generated.
  - On re-entry, keys still held are re-reported as presses after DEBOUNCE_SCANS samples.
- Glitch: a difference shorter than DEBOUNCE_SCANS consecutive samples of its column produces no event. A matching sample resets that key's counter.
- Simultaneous events: up to 4 rows may flip in one SAMPLE; they are emitted in ascending row order, one per accepted handshake.

Test Plan:
- Reset: drive rst_n low asynchronously mid-SETTLE at selector 7 -> without a clock edge, selector = 0, key_valid = 0, scan_active = 0, frame_tick = 0.
- Scan timing (DWELL_CYCLES = 4, row_in = 0, mode = 0) -> selector steps every 6 cycles 0..15 -> 0; frame_tick pulses once per 96 cycles, coincident with 15 -> 0; key_valid stays 0.
- Debounce (DEBOUNCE_SCANS = 3):
  - Assert row_in[2] only while selector == 5 -> after the 3rd sample, key_valid = 1, key_code = 0x16, key_press = 1.
  - Then release row_in[2] -> 0x16 with key_press = 0 after 3 frames.
  - A 2-frame glitch -> no event.
- Backpressure: rows 0 and 3 of column 9 flip together, key_ready = 0 for 10 cycles -> key_valid held, key_code = 0x24, selector stays 9. Raise key_ready -> 0x24 accepted, then 0x27 presented the next cycle, then selector -> 10.
- Mode exit during EMIT: mode -> 1 while key_valid = 1 -> next cycle key_valid = 0, selector = 0, scan_active = 0. Return mode to 0 with the key still held -> press event reissued after 3 frames.
- Wrap with event: a key flip on column 15 with immediate ready -> event accepted, then the NEXT cycle shows selector = 0 and frame_tick = 1.
